// File: rtl/rf_write_scheduler_pkg.sv
// rtl/rf_write_scheduler_pkg.sv - shared constants, state enum and index-width helper
//   ADDR_WIDTH_DEF / WORD_LEN_DEF / NREQ_DEF : default geometry of the write port
//   REQ_ALU / REQ_LSU / REQ_CSR              : requester slot indices
//   state_e                                  : INIT (clear sweep) / RUN (arbitration)
package npc_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int WORD_LEN_DEF   = 32;
  localparam int NREQ_DEF       = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_CSR = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Width of an index into n slots; never zero so a single requester still gets a 1-bit field.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_write_scheduler_if.sv
// rtl/rf_write_scheduler_if.sv - writeback request bundle between requesters and the scheduler
//   req_valid [NREQ]            : per-requester write request
//   req_waddr [NREQ*ADDR_WIDTH] : flattened destination addresses, slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata [NREQ*WORD_LEN]   : flattened write data, slice i = [i*WORD_LEN +: WORD_LEN]
//   req_ready [NREQ]            : one-hot or zero grant; accept on valid & ready at the rising edge
//   master : requester side, slave : scheduler side
interface rf_write_scheduler_if #(
  parameter int NREQ       = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int WORD_LEN   = 32
) ();

  logic [NREQ-1:0]            req_valid;
  logic [NREQ*ADDR_WIDTH-1:0] req_waddr;
  logic [NREQ*WORD_LEN-1:0]   req_wdata;
  logic [NREQ-1:0]            req_ready;

  modport master (
    output req_valid,
    output req_waddr,
    output req_wdata,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_waddr,
    input  req_wdata,
    output req_ready
  );

endinterface

// File: rtl/rf_write_scheduler_rr_arbiter.sv
// rtl/rf_write_scheduler_rr_arbiter.sv - combinational round-robin arbiter
//   req [N] : request vector
//   ptr     : highest-priority index this cycle (0..N-1)
//   gnt [N] : one-hot grant to the first requester at or after ptr (with wrap), zero if none
module rr_arbiter
  import npc_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [N-1:0]          gnt
);

  logic found;

  // Walk the priority distance k outward from ptr; the inner loop finds the slot
  // sitting k places above ptr so every index stays a loop constant.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i == ((int'(ptr) + k) % N))) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// rtl/rf_write_scheduler.sv - register-file write-port scheduler: clear sweep then round-robin writeback
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   wb        : writeback request bundle (slave side)
//   rf_wen    : registered register-file write enable
//   rf_waddr  : registered register-file write address
//   rf_wdata  : registered register-file write data
//   init_done : high once every register has been cleared
//   grant_id  : registered index of the last accepted requester
module rf_write_scheduler
  import npc_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int WORD_LEN   = WORD_LEN_DEF,
  parameter int NREQ       = NREQ_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  rf_write_scheduler_if.slave       wb,
  output logic                      rf_wen,
  output logic [ADDR_WIDTH-1:0]     rf_waddr,
  output logic [WORD_LEN-1:0]       rf_wdata,
  output logic                      init_done,
  output logic [idx_w(NREQ)-1:0]    grant_id
);

  localparam int PW = idx_w(NREQ);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [PW-1:0]         LAST_IDX  = PW'(NREQ - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [WORD_LEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic [PW-1:0]         grant_q, grant_d;

  logic [NREQ-1:0]       gnt;
  logic                  accept;
  logic [PW-1:0]         acc_idx;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [WORD_LEN-1:0]   acc_data;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req (wb.req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  // The port is owned by the clear sweep until RUN, so grants are masked there.
  assign wb.req_ready = (state_q == ST_RUN) ? gnt : '0;
  assign accept       = (state_q == ST_RUN) && (|gnt);

  // Decode the one-hot grant into the winning index and its address/data slices.
  always_comb begin
    acc_idx  = '0;
    acc_addr = '0;
    acc_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        acc_idx  = PW'(i);
        acc_addr = wb.req_waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        acc_data = wb.req_wdata[i*WORD_LEN +: WORD_LEN];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    grant_d    = grant_q;
    case (state_q)
      ST_INIT: begin
        rf_wen_d   = 1'b1;
        rf_waddr_d = cnt_q;
        rf_wdata_d = '0;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          rf_waddr_d = acc_addr;
          rf_wdata_d = acc_data;
          grant_d    = acc_idx;
          // x0 is hardwired zero: the request is consumed but nothing is written.
          rf_wen_d   = (acc_addr != '0);
          ptr_d      = (acc_idx == LAST_IDX) ? '0 : acc_idx + 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      ptr_q      <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      grant_q    <= grant_d;
    end
  end

  assign rf_wen    = rf_wen_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign grant_id  = grant_q;
  assign init_done = (state_q == ST_RUN);

endmodule

// File: tb/tb_rf_write_scheduler.sv
// tb/tb_rf_write_scheduler.sv - scoreboard bench for rf_write_scheduler
module tb_rf_write_scheduler;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  gid;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        init_done;
  logic [1:0]  grant_id;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  logic pend = 1'b0;

  rf_write_scheduler_if #(.NREQ(3), .ADDR_WIDTH(5), .WORD_LEN(32)) wb ();

  rf_write_scheduler #(.ADDR_WIDTH(5), .WORD_LEN(32), .NREQ(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb        (wb),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .init_done (init_done),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wen, input logic [4:0] addr, input logic [31:0] data,
                      input logic [1:0] gid);
    exp_t e;
    e.wen  = wen;
    e.addr = addr;
    e.data = data;
    e.gid  = gid;
    sb.push_back(e);
  endtask

  task automatic sweep_push();
    for (int a = 0; a < 32; a++) push(1'b1, 5'(a), 32'h0, 2'd0);
  endtask

  // 32 sweep edges; init_done must be low after edges 0..30 and high after edge 31.
  task automatic sweep_run(input string tag);
    for (int k = 0; k < 32; k++) begin
      tick();
      chk({tag, "_init_done"}, {63'h0, init_done}, {63'h0, (k == 31)});
    end
  endtask

  // Monitor: an output is due after every enabled write and after every accept,
  // including accepted x0 writes that leave rf_wen low.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend = 1'b0;
      end else begin
        if (pend || rf_wen) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected actual wen=%0b addr=%0d data=%0h gid=%0d expected none",
                     rf_wen, rf_waddr, rf_wdata, grant_id);
          end else begin
            e = sb.pop_front();
            if (rf_wen !== e.wen || rf_waddr !== e.addr || rf_wdata !== e.data ||
                grant_id !== e.gid) begin
              failures++;
              $display("FAIL sb_write actual wen=%0b addr=%0d data=%0h gid=%0d expected wen=%0b addr=%0d data=%0h gid=%0d",
                       rf_wen, rf_waddr, rf_wdata, grant_id, e.wen, e.addr, e.data, e.gid);
            end
          end
        end
        pend = |(wb.req_valid & wb.req_ready);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    wb.req_valid = '0;
    wb.req_waddr = '0;
    wb.req_wdata = '0;
    #2;
    chk("rst_wen", {63'h0, rf_wen}, 64'h0);
    chk("rst_waddr", {59'h0, rf_waddr}, 64'h0);
    chk("rst_init_done", {63'h0, init_done}, 64'h0);
    chk("rst_grant_id", {62'h0, grant_id}, 64'h0);
    chk("rst_ready", {61'h0, wb.req_ready}, 64'h0);

    // Clear sweep with no requests.
    sweep_push();
    tick();
    reset = 1'b1;
    sweep_run("sweep1");
    tick();
    chk("post_sweep_wen", {63'h0, rf_wen}, 64'h0);
    chk("idle_ready", {61'h0, wb.req_ready}, 64'h0);

    // Single ALU request.
    wb.req_valid = 3'b001;
    wb.req_waddr = {5'd0, 5'd0, 5'd5};
    wb.req_wdata = {32'h0, 32'h0, 32'hDEADBEEF};
    #1;
    chk("alu_ready", {61'h0, wb.req_ready}, 64'h1);
    push(1'b1, 5'd5, 32'hDEADBEEF, 2'd0);
    tick();
    wb.req_valid = '0;
    tick();

    // x0 write from CSR: accepted, no enable, pointer wraps to 0.
    wb.req_valid = 3'b100;
    wb.req_waddr = {5'd0, 5'd0, 5'd0};
    wb.req_wdata = {32'h1234, 32'h0, 32'h0};
    #1;
    chk("x0_ready", {61'h0, wb.req_ready}, 64'h4);
    push(1'b0, 5'd0, 32'h1234, 2'd2);
    tick();
    wb.req_valid = '0;
    tick();
    chk("x0_wen_low", {63'h0, rf_wen}, 64'h0);

    // All three held valid: rotation 0,1,2,0,1,2 from pointer 0.
    wb.req_valid = 3'b111;
    wb.req_waddr = {5'd3, 5'd2, 5'd1};
    wb.req_wdata = {32'h33333333, 32'h22222222, 32'h11111111};
    for (int i = 0; i < 6; i++) begin
      logic [31:0] d;
      d = (i % 3 == 0) ? 32'h11111111 : (i % 3 == 1) ? 32'h22222222 : 32'h33333333;
      #1;
      chk("rr_ready", {61'h0, wb.req_ready}, 64'h1 << (i % 3));
      push(1'b1, 5'(i % 3 + 1), d, 2'(i % 3));
      tick();
    end
    wb.req_valid = '0;
    tick();
    chk("sb_empty_pre_reset", 64'(sb.size()), 64'h0);

    // LSU request raised during the sweep waits for RUN.
    reset = 1'b0;
    #1;
    chk("rst2_wen", {63'h0, rf_wen}, 64'h0);
    chk("rst2_init_done", {63'h0, init_done}, 64'h0);
    sweep_push();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick();
      chk("sweep2_init_done", {63'h0, init_done}, {63'h0, (k == 31)});
      if (k == 2) begin
        wb.req_valid = 3'b010;
        wb.req_waddr = {5'd0, 5'd9, 5'd0};
        wb.req_wdata = {32'h0, 32'hCAFEF00D, 32'h0};
      end
      #1;
      if (k >= 2 && k < 31) chk("init_ready_low", {61'h0, wb.req_ready}, 64'h0);
      if (k == 31) begin
        chk("lsu_ready_run", {61'h0, wb.req_ready}, 64'h2);
        push(1'b1, 5'd9, 32'hCAFEF00D, 2'd1);
      end
    end
    tick();
    wb.req_valid = '0;
    tick();
    chk("sb_empty_pre_abort", 64'(sb.size()), 64'h0);

    // Reset asserted mid-sweep at counter 17, then a full restart.
    reset = 1'b0;
    sweep_push();
    tick();
    reset = 1'b1;
    repeat (17) tick();
    chk("abort_waddr16", {59'h0, rf_waddr}, 64'd16);
    chk("abort_wen_before", {63'h0, rf_wen}, 64'h1);
    reset = 1'b0;
    #1;
    chk("abort_wen", {63'h0, rf_wen}, 64'h0);
    chk("abort_waddr", {59'h0, rf_waddr}, 64'h0);
    chk("abort_init_done", {63'h0, init_done}, 64'h0);
    sb.delete();
    tick();
    tick();
    sweep_push();
    reset = 1'b1;
    sweep_run("sweep3");
    tick();
    chk("sweep3_wen_low", {63'h0, rf_wen}, 64'h0);

    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
